// File: rtl/traffic_seq.sv
// traffic_seq: traffic-light sequencer with a latched pedestrian request.
//
// The whole block runs on clk. An internal prescaler produces a one-cycle
// tick every TICK_DIV clocks, and the lamp FSM advances only on a tick.
// A pedestrian request can cut green short (after GREEN_MIN ticks) and
// lengthens the following red by PED_EXT ticks while the walk lamp is lit.
//
// Optional feature: define TRAFFIC_SEQ_FLASH_EN to add a night-flash mode.
// In that mode the yellow lamp blinks once per tick while flash is high.
// Without the macro the flash input is accepted and ignored.
//
// Parameters:
//   TICK_DIV   clk cycles per tick (>= 2)
//   GREEN_T    green duration in ticks
//   YELLOW_T   yellow duration in ticks
//   RED_T      red duration in ticks
//   GREEN_MIN  green ticks before a request may end green (1..GREEN_T)
//   PED_EXT    extra red ticks when walk is granted (0 allowed)
//
// Ports:
//   clk          single clock
//   rst          synchronous, active-high reset
//   pb0          asynchronous pedestrian button, active high
//   flash        night-flash request (used only with TRAFFIC_SEQ_FLASH_EN)
//   LED[2:0]     one-hot lamp: 001 green, 010 yellow, 100 red
//   LED3         walk lamp
//   ped_pending  request latched but not yet served

module traffic_seq #(
  parameter int TICK_DIV  = 13500000,
  parameter int GREEN_T   = 4,
  parameter int YELLOW_T  = 1,
  parameter int RED_T     = 6,
  parameter int GREEN_MIN = 2,
  parameter int PED_EXT   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pb0,
  input  logic       flash,
  output logic [2:0] LED,
  output logic       LED3,
  output logic       ped_pending
);

  // Prescaler width covers 0..TICK_DIV-1.
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  // Tick timer covers the longest phase, including an extended red.
  localparam int RED_EXT_T = RED_T + PED_EXT;
  localparam int T_MAX0    = (GREEN_T > YELLOW_T) ? GREEN_T : YELLOW_T;
  localparam int T_MAX     = (T_MAX0 > RED_EXT_T) ? T_MAX0 : RED_EXT_T;
  localparam int TMR_W     = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  // Phase ends are stored as "last tick index" so a phase of N ticks
  // finishes when tmr == N-1.
  localparam logic [TMR_W-1:0] GREEN_LAST   = TMR_W'(GREEN_T - 1);
  localparam logic [TMR_W-1:0] GREEN_MIN_LT = TMR_W'(GREEN_MIN - 1);
  localparam logic [TMR_W-1:0] YELLOW_LAST  = TMR_W'(YELLOW_T - 1);
  localparam logic [TMR_W-1:0] RED_LAST     = TMR_W'(RED_T - 1);
  localparam logic [TMR_W-1:0] RED_EXT_LAST = TMR_W'(RED_EXT_T - 1);

  localparam logic [2:0] LED_GREEN  = 3'b001;
  localparam logic [2:0] LED_YELLOW = 3'b010;
  localparam logic [2:0] LED_RED    = 3'b100;

`ifdef TRAFFIC_SEQ_FLASH_EN
  localparam logic [2:0] LED_OFF = 3'b000;
  typedef enum logic [1:0] {S_GREEN, S_YELLOW, S_RED, S_FLASH} state_t;
`else
  typedef enum logic [1:0] {S_GREEN, S_YELLOW, S_RED} state_t;
`endif

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [TMR_W-1:0] tmr;
  logic [TMR_W-1:0] red_last;   // last tick index of the current red
  logic             pb_s1, pb_s2, pb_s3;
  logic             tick;
  logic             pb_rise;
  logic             red_entry;  // this edge moves YELLOW -> RED
  logic             ped_block;  // requests are suppressed this edge

`ifdef TRAFFIC_SEQ_FLASH_EN
  logic fl_s1, fl_s2;
`else
  // The flash port is part of the fixed pinout but has no function here.
  logic unused_flash;
  assign unused_flash = flash;
`endif

  assign tick    = (cnt == CNT_LAST);
  // pb_s3 only remembers the previous synchronised level for edge detect.
  assign pb_rise = pb_s2 & ~pb_s3;

  // NOTE: every signal written here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    red_entry = tick && (state == S_YELLOW) && (tmr == YELLOW_LAST);
    ped_block = 1'b0;
`ifdef TRAFFIC_SEQ_FLASH_EN
    // Flash entry has priority over every normal transition, and no
    // request may be latched while flashing or on the way in.
    red_entry = red_entry && !fl_s2;
    ped_block = (state == S_FLASH) || (tick && fl_s2);
`endif
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_GREEN;
      cnt         <= '0;
      tmr         <= '0;
      red_last    <= RED_LAST;
      LED         <= LED_GREEN;
      LED3        <= 1'b0;
      ped_pending <= 1'b0;
      pb_s1       <= 1'b0;
      pb_s2       <= 1'b0;
      pb_s3       <= 1'b0;
`ifdef TRAFFIC_SEQ_FLASH_EN
      fl_s1       <= 1'b0;
      fl_s2       <= 1'b0;
`endif
    end else begin
      cnt   <= tick ? '0 : cnt + 1'b1;
      pb_s1 <= pb0;
      pb_s2 <= pb_s1;
      pb_s3 <= pb_s2;
`ifdef TRAFFIC_SEQ_FLASH_EN
      fl_s1 <= flash;
      fl_s2 <= fl_s1;
`endif

      // Pending request: a fresh edge wins over a grant on the same edge,
      // so an edge coinciding with red entry waits for the next red.
      if (ped_block)          ped_pending <= 1'b0;
      else if (pb_rise)       ped_pending <= 1'b1;
      else if (red_entry && ped_pending) ped_pending <= 1'b0;

      if (tick) begin
`ifdef TRAFFIC_SEQ_FLASH_EN
        if (fl_s2) begin
          state <= S_FLASH;
          tmr   <= '0;
          LED3  <= 1'b0;
          // First flash tick shows yellow, then alternate with dark.
          LED   <= (state == S_FLASH && LED == LED_YELLOW) ? LED_OFF : LED_YELLOW;
        end else if (state == S_FLASH) begin
          state    <= S_RED;
          tmr      <= '0;
          red_last <= RED_LAST;
          LED      <= LED_RED;
        end else
`endif
        begin
          case (state)
            S_GREEN: begin
              // Early exit looks at the pre-edge ped_pending, so a button
              // edge on this same clock does not alter the decision.
              if (tmr == GREEN_LAST || (ped_pending && tmr >= GREEN_MIN_LT)) begin
                state <= S_YELLOW;
                tmr   <= '0;
                LED   <= LED_YELLOW;
              end else begin
                tmr <= tmr + 1'b1;
              end
            end
            S_YELLOW: begin
              if (tmr == YELLOW_LAST) begin
                state <= S_RED;
                tmr   <= '0;
                LED   <= LED_RED;
                if (ped_pending) begin
                  LED3     <= 1'b1;
                  red_last <= RED_EXT_LAST;
                end else begin
                  red_last <= RED_LAST;
                end
              end else begin
                tmr <= tmr + 1'b1;
              end
            end
            S_RED: begin
              if (tmr == red_last) begin
                state <= S_GREEN;
                tmr   <= '0;
                LED   <= LED_GREEN;
                LED3  <= 1'b0;
              end else begin
                tmr <= tmr + 1'b1;
              end
            end
            default: begin
              // Unreachable encodings recover to a clean green.
              state <= S_GREEN;
              tmr   <= '0;
              LED   <= LED_GREEN;
              LED3  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule
